mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter.sv | 161 ++++++++++++++++
 tb/tb_mdu_iter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit, one iteration per clock.
//
// Works on operand magnitudes: shift-add for multiply, restoring
// shift-subtract for divide, followed by a sign-correction step. With
// WIDTH = N, a result appears N+1 clock edges after the request is
// accepted.
//
// Ports
//   clk_i    sole clock, rising edge
//   rst_ni   asynchronous active-low reset
//   start_i  request; sampled in IDLE and in the FIN (done) cycle
//   op_i     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a_i      multiplicand / dividend, captured with start_i
//   b_i      multiplier / divisor, captured with start_i
//   flush_i  synchronous abort; forces IDLE on the next edge
//   busy_o   unit occupied (CALC or FIN)
//   done_o   one-cycle completion pulse (FIN)
//   hi_o     product upper half / remainder
//   lo_o     product lower half / quotient
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | WIDTH iterations, then the sign-correction / result-write edge
// FIN   | result on hi_o/lo_o, done_o high, can accept a new request
module mdu_iter #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic               div_q, neg_a_q, neg_b_q, bzero_q;
    logic [WIDTH-1:0]   mb_q, acc_hi_q, acc_lo_q, hi_q, lo_q;

    logic               accept, last_iter;
    logic               in_signed, in_neg_a, in_neg_b;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   step_hi, step_lo, res_hi, res_lo;
    logic [2*WIDTH-1:0] mul_full, mul_res;

    // A new request can also be taken in the done cycle, giving back-to-back operation.
    assign accept    = start_i && !flush_i && (state_q == IDLE || state_q == FIN);
    assign last_iter = (state_q == CALC) && (cnt_q == CW'(WIDTH));

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    assign in_signed = SIGNED_EN && op_i[0];
    assign in_neg_a  = in_signed && a_i[WIDTH-1];
    assign in_neg_b  = in_signed && b_i[WIDTH-1];
    assign in_mag_a  = in_neg_a ? -a_i : a_i;
    assign in_mag_b  = in_neg_b ? -b_i : b_i;

    // One iteration: acc_hi holds partial product / partial remainder,
    // acc_lo holds multiplier bits / dividend bits becoming quotient bits.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mb_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ok    = div_shift >= {1'b0, mb_q};
        if (div_q) begin
            step_hi = div_ok ? WIDTH'(div_shift - {1'b0, mb_q}) : div_shift[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // Sign correction. A zero divisor makes every subtract succeed, so the
    // remainder ends as |a| (re-signed to a); only the quotient is forced to all ones.
    always_comb begin
        mul_full = {acc_hi_q, acc_lo_q};
        mul_res  = (neg_a_q ^ neg_b_q) ? -mul_full : mul_full;
        if (div_q) begin
            res_lo = bzero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q);
            res_hi = neg_a_q ? -acc_hi_q : acc_hi_q;
        end else begin
            res_hi = mul_res[2*WIDTH-1:WIDTH];
            res_lo = mul_res[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC: begin
                if (flush_i)        state_d = IDLE;
                else if (last_iter) state_d = FIN;
            end
            FIN:     state_d = accept ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == FIN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            div_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            bzero_q  <= 1'b0;
            mb_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            div_q    <= op_i[1];
            neg_a_q  <= in_neg_a;
            neg_b_q  <= in_neg_b;
            bzero_q  <= (b_i == '0);
            mb_q     <= in_mag_b;
            acc_hi_q <= '0;
            acc_lo_q <= in_mag_a;
        end else if (state_q == CALC && !flush_i) begin
            if (last_iter) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else begin
                acc_hi_q <= step_hi;
                acc_lo_q <= step_lo;
                cnt_q    <= cnt_q + CW'(1);
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter (WIDTH=32, SIGNED_EN=1): directed vectors plus
// randomized operations, scoreboard queue checked by a done-driven monitor.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    mdu_iter #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .flush_i (flush),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] h;
        logic [W-1:0] l;
        int           c;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain 64-bit integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output logic [W-1:0] h, output logic [W-1:0] l);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = longint'({32'b0, av});
        ub = longint'({32'b0, bv});
        h = '0;
        l = '0;
        case (o)
            2'd0: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
            2'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            2'd2: begin
                if (bv == 0) begin l = '1; h = av; end
                else begin l = W'(ua / ub); h = W'(ua % ub); end
            end
            default: begin
                if (bv == 0) begin l = '1; h = av; end
                else begin l = W'(sa / sb); h = W'(sa % sb); end
            end
        endcase
    endfunction

    // Called at a negedge; request is sampled on the next posedge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit acc, input bit fl, input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_t e;
        start = 1'b1;
        flush = fl;
        op = o;
        a = av;
        b = bv;
        if (acc) begin
            e.h = eh;
            e.l = el;
            e.c = cyc + 1 + W + 1;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic issue_m(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] h, l;
        model(o, av, bv, h, l);
        issue(o, av, bv, 1'b1, 1'b0, h, l);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3 * W) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s: got no done within %0d cycles, expected done", name, n);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected 0", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("result_hi", hi, mon_e.h);
                chk("result_lo", lo, mon_e.l);
                chk("done_cycle", W'(cyc), W'(mon_e.c));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        int sel;

        #3;
        chk("reset_busy", W'(busy), 0);
        chk("reset_done", W'(done), 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release accepts; busy spans cycles 0..W+1.
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        for (int k = 0; k <= W + 1; k++) begin
            chk("busy_active", W'(busy), 1);
            if (k < W + 1) @(negedge clk);
        end
        @(negedge clk);
        chk("busy_after", W'(busy), 0);

        // Back-to-back chain of spec vectors, each issued in the previous done cycle.
        issue(2'd1, -32'sd7, 32'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        wait_done("mult");
        issue(2'd3, -32'sd7, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done("div");
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 32'h8000_0000);
        wait_done("div_ovf");
        issue(2'd2, 32'd5, 32'd0, 1'b1, 1'b0, 32'd5, 32'hFFFF_FFFF);
        wait_done("divu_zero");
        @(negedge clk);

        // Flush mid-operation: no done, outputs held.
        issue(2'd2, 32'd100, 32'd7, 1'b0, 1'b0, 0, 0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", W'(busy), 0);
        chk("flush_hold_hi", hi, 32'd5);
        chk("flush_hold_lo", lo, 32'hFFFF_FFFF);
        repeat (W + 8) @(negedge clk);
        issue(2'd2, 32'd100, 32'd7, 1'b1, 1'b0, 32'd2, 32'd14);
        wait_done("divu_after_flush");
        @(negedge clk);

        // Start while busy is ignored.
        issue_m(2'd0, 32'd1234, 32'd5678);
        repeat (4) @(negedge clk);
        issue(2'd1, 32'd9, 32'd9, 1'b0, 1'b0, 0, 0);
        wait_done("busy_start");
        @(negedge clk);
        chk("busy_start_idle", W'(busy), 0);
        repeat (W + 4) @(negedge clk);

        // Flush and start together in IDLE: flush wins.
        issue(2'd1, 32'd3, 32'd3, 1'b0, 1'b1, 0, 0);
        chk("flush_start_busy", W'(busy), 0);
        repeat (3) @(negedge clk);

        // Flush in the FIN cycle: done still pulses, results stand.
        issue_m(2'd0, 32'd9, 32'd9);
        wait_done("fin_flush");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fin_flush_busy", W'(busy), 0);
        chk("fin_flush_hi", hi, 32'd0);
        chk("fin_flush_lo", lo, 32'd81);

        // Reset mid-operation.
        issue_m(2'd0, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", W'(busy), 0);
        chk("arst_done", W'(done), 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 8) @(negedge clk);
        chk("post_rst_busy", W'(busy), 0);

        // Randomized operations, some back-to-back, some with idle gaps.
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 7);
            ra = $urandom;
            rb = $urandom;
            if (sel == 0) rb = '0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = '1; end
            else if (sel == 2) rb = W'($urandom_range(1, 15));
            else if (sel == 3) rb = -W'($urandom_range(1, 15));
            issue_m(2'($urandom), ra, rb);
            wait_done("random");
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        @(negedge clk);

        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
